// File: rtl/ttt_win_judge_if.sv
// Board-in / result-out bundle between the game controller, the win judge
// and the display stage.
interface ttt_win_judge_if;
    logic [8:0] game_mem;
    logic [8:0] grid_active;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic       game_over;
    logic [8:0] win_mask;
    logic [8:0] blink_mask;

    modport master (
        output game_mem, grid_active, start,
        input  busy, done, winner, game_over, win_mask, blink_mask
    );

    modport slave (
        input  game_mem, grid_active, start,
        output busy, done, winner, game_over, win_mask, blink_mask
    );
endinterface

// File: rtl/ttt_win_judge.sv
// Tic-tac-toe win/draw judge: scans the 8 winning lines one per clock on a
// board snapshot, latches the result and blinks the winning cells.
//
// state  | meaning
// IDLE   | results held, waiting for start or a change of grid_active
// SCAN   | evaluating line[line_idx] of the snapshot, one line per cycle
// FINISH | results visible, done high; rescan if a trigger arrived meanwhile
module ttt_win_judge #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic            clk,
    input  logic            areset_i,
    ttt_win_judge_if.slave  bus
);
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t        state, state_nxt;
    logic [2:0]    line_idx;
    logic          pending;
    logic [8:0]    grid_prev;
    logic [8:0]    snap_mem, snap_act;
    logic [1:0]    scr_winner, scr_winner_nxt;
    logic [8:0]    scr_mask, scr_mask_nxt;
    logic [1:0]    fin_winner;
    logic [8:0]    fin_mask;
    logic [1:0]    winner_q;
    logic [8:0]    win_mask_q, blink_mask_q;
    logic [CW-1:0] blink_cnt;
    logic          blink_phase;
    logic          trigger, load_snap, last_line;
    logic [8:0]    cells;
    logic          line_win, line_owner;

    function automatic logic [8:0] line_cells(input logic [2:0] idx);
        case (idx)
            3'd0:    return 9'b000_000_111;
            3'd1:    return 9'b000_111_000;
            3'd2:    return 9'b111_000_000;
            3'd3:    return 9'b001_001_001;
            3'd4:    return 9'b010_010_010;
            3'd5:    return 9'b100_100_100;
            3'd6:    return 9'b100_010_001;
            default: return 9'b001_010_100;
        endcase
    endfunction

    always_comb begin
        trigger    = bus.start | (bus.grid_active != grid_prev);
        last_line  = (line_idx == 3'd7);
        cells      = line_cells(line_idx);
        line_win   = ((snap_act & cells) == cells) &&
                     (((snap_mem & cells) == cells) || ((snap_mem & cells) == 9'h000));
        line_owner = |(snap_mem & cells);

        // First winning line in scan order decides the winner; all winning lines add to the mask.
        scr_winner_nxt = scr_winner;
        if (line_win && (scr_winner == 2'b00))
            scr_winner_nxt = {line_owner, ~line_owner};
        scr_mask_nxt = scr_mask | (line_win ? cells : 9'h000);

        fin_winner = scr_winner_nxt;
        fin_mask   = scr_mask_nxt;
        if ((scr_winner_nxt == 2'b00) && (snap_act == 9'h1FF)) begin
            fin_winner = 2'b11;
            fin_mask   = 9'h000;
        end
    end

    always_comb begin
        state_nxt = state;
        load_snap = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = SCAN;
                    load_snap = 1'b1;
                end
            end
            SCAN: begin
                if (last_line)
                    state_nxt = FINISH;
            end
            FINISH: begin
                if (pending || trigger) begin
                    state_nxt = SCAN;
                    load_snap = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset_i) begin
        if (areset_i) begin
            state      <= IDLE;
            line_idx   <= 3'd0;
            pending    <= 1'b0;
            grid_prev  <= 9'h000;
            snap_mem   <= 9'h000;
            snap_act   <= 9'h000;
            scr_winner <= 2'b00;
            scr_mask   <= 9'h000;
            winner_q   <= 2'b00;
            win_mask_q <= 9'h000;
        end else begin
            state     <= state_nxt;
            grid_prev <= bus.grid_active;

            if (state == FINISH)
                pending <= 1'b0;
            else if ((state == SCAN) && trigger)
                pending <= 1'b1;

            if (load_snap) begin
                snap_mem   <= bus.game_mem;
                snap_act   <= bus.grid_active;
                scr_winner <= 2'b00;
                scr_mask   <= 9'h000;
                line_idx   <= 3'd0;
            end else if (state == SCAN) begin
                scr_winner <= scr_winner_nxt;
                scr_mask   <= scr_mask_nxt;
                line_idx   <= line_idx + 3'd1;
                // Results land on the edge into FINISH so they are valid alongside done.
                if (last_line) begin
                    winner_q   <= fin_winner;
                    win_mask_q <= fin_mask;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge areset_i) begin
        if (areset_i) begin
            blink_cnt    <= '0;
            blink_phase  <= 1'b1;
            blink_mask_q <= 9'h000;
        end else begin
            if (winner_q == 2'b00) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (blink_cnt == CNT_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + CW'(1);
            end
            blink_mask_q <= blink_phase ? ((winner_q == 2'b11) ? 9'h1FF : win_mask_q) : 9'h000;
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == FINISH);
    assign bus.winner     = winner_q;
    assign bus.game_over  = (winner_q != 2'b00);
    assign bus.win_mask   = win_mask_q;
    assign bus.blink_mask = blink_mask_q;
endmodule

// File: tb/tb_ttt_win_judge.sv
// Directed bench for ttt_win_judge: board vectors with hand-computed results,
// plus blink, mid-scan retrigger and mid-scan reset sequences.
module tb_ttt_win_judge;
    logic clk = 1'b0;
    logic areset_i = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ttt_win_judge_if bus();

    ttt_win_judge #(.BLINK_DIV(4)) dut (
        .clk      (clk),
        .areset_i (areset_i),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] grid;
        logic [8:0] mem;
        logic       use_start;
        logic [1:0] exp_win;
        logic [8:0] exp_mask;
        logic       chk_blink;
        logic [8:0] blink_on;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
            if (bus.done) seen = 1'b1;
        end
    endtask

    // Interior runs of blink_mask must be exactly 4 cycles, values only on/off.
    task automatic check_blink(input logic [8:0] on_val);
        logic [8:0] prev, v;
        int run, nruns;
        bit seen_edge, bad_val;
        @(posedge clk); #1;
        prev = bus.blink_mask;
        run = 1; nruns = 0; seen_edge = 1'b0; bad_val = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            v = bus.blink_mask;
            if (v !== on_val && v !== 9'h000) bad_val = 1'b1;
            if (v === prev) begin
                run++;
            end else begin
                if (seen_edge) begin
                    chk("blink_run_len", run, 4);
                    nruns++;
                end
                seen_edge = 1'b1;
                run = 1;
                prev = v;
            end
        end
        chk("blink_values", bad_val, 0);
        chk("blink_toggles", (nruns >= 3), 1);
    endtask

    initial begin
        int cyc;
        int ndone, busy_low;
        int dcyc[2];
        logic [1:0] dwin[2];
        logic [8:0] dmask[2];

        vecs[0] = '{9'h007, 9'h000, 1'b0, 2'b01, 9'h007, 1'b1, 9'h007};
        vecs[1] = '{9'h054, 9'h054, 1'b0, 2'b10, 9'h054, 1'b0, 9'h000};
        vecs[2] = '{9'h000, 9'h000, 1'b1, 2'b00, 9'h000, 1'b0, 9'h000};
        vecs[3] = '{9'h092, 9'h092, 1'b0, 2'b10, 9'h092, 1'b0, 9'h000};
        vecs[4] = '{9'h003, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 9'h000};
        vecs[5] = '{9'h1FF, 9'h1B0, 1'b0, 2'b01, 9'h04F, 1'b0, 9'h000};
        vecs[6] = '{9'h1FF, 9'h072, 1'b1, 2'b11, 9'h000, 1'b1, 9'h1FF};

        bus.game_mem = 9'h000;
        bus.grid_active = 9'h000;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_winner", bus.winner, 0);
        chk("rst_game_over", bus.game_over, 0);
        chk("rst_win_mask", bus.win_mask, 0);
        chk("rst_blink_mask", bus.blink_mask, 0);
        areset_i = 1'b0;

        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            bus.grid_active = vecs[k].grid;
            bus.game_mem = vecs[k].mem;
            bus.start = vecs[k].use_start;
            wait_done(cyc);
            chk($sformatf("v%0d_latency", k), cyc, 9);
            chk($sformatf("v%0d_winner", k), bus.winner, vecs[k].exp_win);
            chk($sformatf("v%0d_win_mask", k), bus.win_mask, vecs[k].exp_mask);
            chk($sformatf("v%0d_game_over", k), bus.game_over, (vecs[k].exp_win != 2'b00));
            if (vecs[k].chk_blink) check_blink(vecs[k].blink_on);
        end

        // Board changes 3 cycles into a scan: old result first, new one 9 cycles later.
        @(posedge clk); #1;
        bus.grid_active = 9'h054;
        bus.game_mem = 9'h054;
        bus.start = 1'b1;
        ndone = 0; busy_low = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (i == 3) begin
                bus.grid_active = 9'h007;
                bus.game_mem = 9'h000;
            end
            if (i <= 18 && !bus.busy) busy_low++;
            if (bus.done) begin
                if (ndone < 2) begin
                    dcyc[ndone] = i;
                    dwin[ndone] = bus.winner;
                    dmask[ndone] = bus.win_mask;
                end
                ndone++;
            end
        end
        chk("mid_done_count", ndone, 2);
        chk("mid_busy_held", busy_low, 0);
        if (ndone >= 2) begin
            chk("mid_done1_cycle", dcyc[0], 9);
            chk("mid_done1_winner", dwin[0], 2'b10);
            chk("mid_done1_mask", dmask[0], 9'h054);
            chk("mid_done2_cycle", dcyc[1], 18);
            chk("mid_done2_winner", dwin[1], 2'b01);
            chk("mid_done2_mask", dmask[1], 9'h007);
        end

        // Asynchronous reset in the middle of a scan.
        @(posedge clk); #1;
        bus.grid_active = 9'h000;
        bus.game_mem = 9'h000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_busy_before", bus.busy, 1);
        chk("rst_mid_winner_before", bus.winner, 2'b01);
        areset_i = 1'b1;
        #1;
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_done", bus.done, 0);
        chk("rst_mid_winner", bus.winner, 0);
        chk("rst_mid_game_over", bus.game_over, 0);
        chk("rst_mid_win_mask", bus.win_mask, 0);
        chk("rst_mid_blink_mask", bus.blink_mask, 0);
        @(posedge clk); #1;
        areset_i = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("rst_no_spurious_done", ndone, 0);
        bus.start = 1'b1;
        wait_done(cyc);
        chk("post_rst_latency", cyc, 9);
        chk("post_rst_winner", bus.winner, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ttt_win_judge.md
Name:
ttt_win_judge

Overview:
- Downstream stage of the tic-tac-toe game controller. Consumes its board outputs: GameMem[8:0] (owner bit per cell) and GridActive[8:0] (occupied bit per cell).
- Cell index = 3*row + col, with cells 0..8. A game_mem bit of 0 means player 0 (first mover); 1 means player 1.
- Checks the 8 winning lines one per clock with a small FSM. Latches winner, draw and winning-cell mask.
- Drives a blinking LED mask that highlights the winning line for the display stage.

Parameters:
BLINK_DIV, 25000000, number of clk cycles per blink half-period (must be >= 2; benches use 4).

Ports:
clk  in  1  system clock; all state on rising edge
areset_i  in  1  reset, asynchronous, active-high
game_mem  in  9  owner bit per cell, from the game controller
grid_active  in  9  occupied bit per cell, from the game controller
start  in  1  one-cycle request to re-evaluate the board
busy  out  1  evaluation in progress
done  out  1  one-cycle pulse: results updated this cycle
winner  out  2  00 none, 01 player 0, 10 player 1, 11 draw
game_over  out  1  winner != 00
win_mask  out  9  cells belonging to any winning line
blink_mask  out  9  win_mask gated by blink phase (all cells on draw)

Behaviour:
- Reset: the FSM goes to IDLE. busy, done, winner, game_over, win_mask, blink_mask, pending, line_idx, grid_prev, blink counter are all cleared to 0, and blink phase is set to 1. Asserting reset mid-scan aborts the scan and discards partial results.
- grid_prev register: loaded with grid_active every cycle.
- trigger: start OR (grid_active != grid_prev).
- States:
  - IDLE: if trigger, capture snap_mem <= game_mem and snap_act <= grid_active, clear the scratch result, set line_idx = 0, go to SCAN.
  - SCAN: evaluate line[line_idx] against the snapshot, increment line_idx. After line 7, go to FINISH.
  - FINISH: copy the scratch result to the outputs and assert done for this cycle only. If pending = 1, clear pending, take a fresh snapshot and go to SCAN. Otherwise go to IDLE.
- busy = 1 in SCAN and FINISH.
- Latency: trigger sampled at edge N gives SCAN during cycles N+1..N+8 and FINISH (done = 1) during cycle N+9. A back-to-back rescan gives its next done 9 cycles later.
- Trigger while busy sets pending. Multiple triggers collapse into one rescan. The snapshot is never modified mid-scan.
- Line order:
  - L0 {0,1,2}, L1 {3,4,5}, L2 {6,7,8} (rows)
  - L3 {0,3,6}, L4 {1,4,7}, L5 {2,5,8} (columns)
  - L6 {0,4,8}, L7 {2,4,6} (diagonals)
- A line wins iff all 3 cells are active and all 3 mem bits are equal. Inactive cells never count, regardless of their mem value.
- The first winning line in scan order sets the scratch winner to 01 (mem = 0) or 10 (mem = 1). Every winning line ORs its 3 cells into the scratch win_mask.
- Draw: at FINISH, if no line won and snap_act == 9'h1FF, winner = 11 and win_mask = 0.
- A cleared board (all inactive) re-scans to winner = 00 and win_mask = 0, which ends game_over.
- Outputs change only in FINISH. Between scans they hold their values.
- Blink logic:
  - While game_over = 0, the counter is held at 0 and phase at 1.
  - While game_over = 1, the counter counts 0..BLINK_DIV-1. On wrap it returns to 0 and phase toggles.
  - blink_mask = phase ? (winner == 11 ? 9'h1FF : win_mask) : 0, registered, valid one cycle after phase or result changes.
- Widths: line_idx is 3 bits. The blink counter is $clog2(BLINK_DIV) bits. No arithmetic overflow paths.

Test Plan:
- Row win: set grid_active = 0x007 and game_mem = 0x000 in one cycle, with BLINK_DIV = 4 -> done 9 cycles later; winner = 01, win_mask = 0x007, game_over = 1; blink_mask alternates 0x007 / 0x000 every 4 cycles.
- Anti-diagonal win for player 1: grid_active = 0x054, game_mem = 0x054 -> winner = 10, win_mask = 0x054. Also drive game_mem = 0x000 with grid_active = 0x000 and pulse start -> winner = 00, since inactive cells do not count.
- Draw: grid_active = 0x1FF, game_mem = 0x072 -> winner = 11, win_mask = 0x000, blink_mask alternates 0x1FF / 0x000.
- Double win: grid_active = 0x1FF, game_mem = 0x1B0 (player 0 owns cells 0, 1, 2, 3 and 6) -> winner = 01, win_mask = 0x04F.
- Mid-scan change: start a scan, change grid_active 3 cycles later -> first done at +9 with the old board's result, second done 9 cycles later with the new result. busy stays high throughout, and exactly 2 done pulses are seen.
- Reset mid-scan: assert areset_i during SCAN -> all outputs 0 immediately (asynchronous); after release, no done pulse occurs until the next trigger.
